// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS memory stage: dmem handshake, big-endian align, exceptions, writeback
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_alu_overflow,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_signed,
  input  logic [31:0] ex_store_data,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_reg_dest,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg_dest,
  output logic [31:0] wb_data,
  output logic        exc_overflow,
  output logic        exc_misaligned,
  output logic        exc_bus
);

  typedef enum logic [0:0] {IDLE, WAIT_ACK} state_t;

  // ACK_TIMEOUT of 0 yields an all-ones LAST_CNT, but TIMEOUT_EN masks it off.
  localparam bit               TIMEOUT_EN = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(ACK_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_read;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic              r_signed;
  logic              r_reg_write;
  logic [4:0]        r_reg_dest;
  logic [31:0]       r_addr;

  logic        w_accept;
  logic        w_is_mem;
  logic        w_misaligned;
  logic        w_exc;
  logic        w_start_mem;
  logic        w_timeout;
  logic        w_we;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign ex_ready     = (r_state == IDLE);
  assign dmem_req     = (r_state == WAIT_ACK);
  assign w_accept     = ex_valid & ex_ready;
  assign w_off        = ex_alu_result[1:0];
  assign w_is_mem     = ex_mem_read | ex_mem_write;
  // Size 3 is treated as a word, so any size with bit 1 set needs word alignment.
  assign w_misaligned = w_is_mem & (((ex_mem_size == 2'd1) & w_off[0]) |
                                    (ex_mem_size[1] & (w_off != 2'b00)));
  assign w_exc        = ex_alu_overflow | w_misaligned;
  assign w_start_mem  = w_accept & w_is_mem & ~w_exc;
  // A read wins when both read and write are requested.
  assign w_we         = ex_mem_write & ~ex_mem_read;
  // Ack in the last allowed cycle takes priority over the abort.
  assign w_timeout    = TIMEOUT_EN & (r_state == WAIT_ACK) & ~dmem_ack & (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state: leave IDLE only for a legal memory op, return on ack or timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_start_mem) w_next = WAIT_ACK;
      WAIT_ACK: if (dmem_ack || w_timeout) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Store lane placement, big-endian: byte lane 3 holds the lowest address
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = 32'h0;
    if (w_we) begin
      case (ex_mem_size)
        2'd0: begin
          w_wdata = {4{ex_store_data[7:0]}};
          w_be    = 4'b1000 >> w_off;
        end
        2'd1: begin
          w_wdata = {2{ex_store_data[15:0]}};
          w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        end
        default: w_wdata = ex_store_data;
      endcase
    end
  end

  // Load extraction and sign/zero extension from the word returned this cycle
  always_comb begin
    case (r_off)
      2'd0:    w_byte = dmem_rdata[31:24];
      2'd1:    w_byte = dmem_rdata[23:16];
      2'd2:    w_byte = dmem_rdata[15:8];
      default: w_byte = dmem_rdata[7:0];
    endcase
    w_half = r_off[1] ? dmem_rdata[15:0] : dmem_rdata[31:16];
    case (r_size)
      2'd0:    w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load_data = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Request capture, timeout counting and the registered writeback bundle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_is_read      <= 1'b0;
      r_size         <= 2'd0;
      r_off          <= 2'd0;
      r_signed       <= 1'b0;
      r_reg_write    <= 1'b0;
      r_reg_dest     <= 5'd0;
      r_addr         <= 32'h0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'h0;
      dmem_be        <= 4'h0;
      dmem_wdata     <= 32'h0;
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      wb_reg_dest    <= 5'd0;
      wb_data        <= 32'h0;
      exc_overflow   <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
    end else begin
      wb_valid       <= 1'b0;
      wb_reg_write   <= 1'b0;
      exc_overflow   <= 1'b0;
      exc_misaligned <= 1'b0;
      exc_bus        <= 1'b0;
      if (w_accept) begin
        r_cnt <= '0;
        if (w_start_mem) begin
          dmem_we     <= w_we;
          dmem_addr   <= {ex_alu_result[31:2], 2'b00};
          dmem_be     <= w_be;
          dmem_wdata  <= w_wdata;
          r_is_read   <= ex_mem_read;
          r_size      <= ex_mem_size;
          r_off       <= w_off;
          r_signed    <= ex_mem_signed;
          r_reg_write <= ex_reg_write;
          r_reg_dest  <= ex_reg_dest;
          r_addr      <= ex_alu_result;
        end else begin
          wb_valid       <= 1'b1;
          wb_data        <= ex_alu_result;
          wb_reg_dest    <= ex_reg_dest;
          wb_reg_write   <= ex_reg_write & ~w_exc;
          exc_overflow   <= ex_alu_overflow;
          exc_misaligned <= ~ex_alu_overflow & w_misaligned;
        end
      end else if (r_state == WAIT_ACK) begin
        if (dmem_ack) begin
          wb_valid     <= 1'b1;
          wb_reg_dest  <= r_reg_dest;
          wb_data      <= r_is_read ? w_load_data : r_addr;
          wb_reg_write <= r_is_read & r_reg_write;
        end else if (w_timeout) begin
          wb_valid    <= 1'b1;
          wb_reg_dest <= r_reg_dest;
          wb_data     <= r_addr;
          exc_bus     <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic        ex_alu_overflow;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [1:0]  ex_mem_size;
  logic        ex_mem_signed;
  logic [31:0] ex_store_data;
  logic        ex_reg_write;
  logic [4:0]  ex_reg_dest;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_dest;
  logic [31:0] wb_data;
  logic        exc_overflow;
  logic        exc_misaligned;
  logic        exc_bus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ACK_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_result(ex_alu_result), .ex_alu_overflow(ex_alu_overflow),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_mem_signed(ex_mem_signed),
    .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write), .ex_reg_dest(ex_reg_dest),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_reg_dest(wb_reg_dest), .wb_data(wb_data),
    .exc_overflow(exc_overflow), .exc_misaligned(exc_misaligned), .exc_bus(exc_bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single accepting edge; stage is IDLE whenever this is called
  task automatic issue(input logic [31:0] addr, input logic ovf, input logic rd, input logic wr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] sdata,
                       input logic rw, input logic [4:0] dest);
    ex_alu_result = addr; ex_alu_overflow = ovf; ex_mem_read = rd; ex_mem_write = wr;
    ex_mem_size = size; ex_mem_signed = sgn; ex_store_data = sdata;
    ex_reg_write = rw; ex_reg_dest = dest; ex_valid = 1'b1;
    tick;
    ex_valid = 1'b0;
  endtask

  // Memory responder: wait 'delay' request cycles, then ack for one cycle
  task automatic ack_after(input int delay, input logic [31:0] rdata);
    for (int i = 0; i < delay; i++) tick;
    dmem_rdata = rdata; dmem_ack = 1'b1;
    tick;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", dmem_req); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%b exp=0", wb_valid); end
    total++; if ({dmem_we, dmem_be, dmem_addr, dmem_wdata} !== 69'h0) begin bad++; $display("FAIL rst_dmem got=%h exp=0", {dmem_we, dmem_be, dmem_addr, dmem_wdata}); end
    total++; if ({wb_data, wb_reg_dest, wb_reg_write, exc_overflow, exc_misaligned, exc_bus} !== 41'h0) begin bad++; $display("FAIL rst_wb got=%h exp=0", {wb_data, wb_reg_dest, wb_reg_write}); end
    rst_n = 1'b1;
    tick;
    total++; if (ex_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ex_ready); end
  endtask

  task automatic test_alu;
    issue(32'h0000_002A, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd5);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL alu_valid got=%b exp=1", wb_valid); end
    total++; if (wb_data !== 32'h0000_002A) begin bad++; $display("FAIL alu_data got=%h exp=0000002a", wb_data); end
    total++; if (wb_reg_write !== 1'b1) begin bad++; $display("FAIL alu_rw got=%b exp=1", wb_reg_write); end
    total++; if (wb_reg_dest !== 5'd5) begin bad++; $display("FAIL alu_dest got=%0d exp=5", wb_reg_dest); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL alu_noreq got=%b exp=0", dmem_req); end
    tick;
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL alu_pulse got=%b exp=0", wb_valid); end
    total++; if (wb_data !== 32'h0000_002A) begin bad++; $display("FAIL alu_hold got=%h exp=0000002a", wb_data); end
  endtask

  task automatic test_loads;
    issue(32'h0000_1001, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 32'h0, 1'b1, 5'd8);
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL lb_req got=%b exp=1", dmem_req); end
    total++; if (ex_ready !== 1'b0) begin bad++; $display("FAIL lb_ready got=%b exp=0", ex_ready); end
    total++; if ({dmem_we, dmem_be, dmem_addr} !== {1'b0, 4'hF, 32'h0000_1000}) begin bad++; $display("FAIL lb_bus got=%h exp=%h", {dmem_we, dmem_be, dmem_addr}, {1'b0, 4'hF, 32'h0000_1000}); end
    total++; if (dmem_wdata !== 32'h0) begin bad++; $display("FAIL lb_wdata got=%h exp=0", dmem_wdata); end
    ack_after(2, 32'h1280_3456);
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL lb_valid got=%b exp=1", wb_valid); end
    total++; if (wb_data !== 32'hFFFF_FF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", wb_data); end
    total++; if ({wb_reg_write, wb_reg_dest} !== {1'b1, 5'd8}) begin bad++; $display("FAIL lb_wb got=%h exp=%h", {wb_reg_write, wb_reg_dest}, {1'b1, 5'd8}); end
    total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL lb_dropreq got=%b exp=0", dmem_req); end
    // lbu with ack in the first request cycle: wb_valid two edges after accept
    issue(32'h0000_1001, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h0, 1'b1, 5'd9);
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL lbu_early got=%b exp=0", wb_valid); end
    ack_after(0, 32'h1280_3456);
    total++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_0080}) begin bad++; $display("FAIL lbu_data got=%h exp=%h", {wb_valid, wb_data}, {1'b1, 32'h0000_0080}); end
    issue(32'h0000_1002, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1, 5'd10);
    ack_after(1, 32'h1280_3456);
    total++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_3456}) begin bad++; $display("FAIL lh_data got=%h exp=%h", {wb_valid, wb_data}, {1'b1, 32'h0000_3456}); end
    issue(32'h0000_1000, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 1'b1, 5'd11);
    ack_after(1, 32'h8001_0000);
    total++; if (wb_data !== 32'hFFFF_8001) begin bad++; $display("FAIL lh_hi_data got=%h exp=ffff8001", wb_data); end
    issue(32'h0000_1004, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd12);
    ack_after(0, 32'hA1B2_C3D4);
    total++; if (wb_data !== 32'hA1B2_C3D4) begin bad++; $display("FAIL lw_data got=%h exp=a1b2c3d4", wb_data); end
  endtask

  task automatic test_stores;
    issue(32'h0000_2002, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'hDEAD_BEEF, 1'b1, 5'd3);
    total++; if ({dmem_req, dmem_we} !== 2'b11) begin bad++; $display("FAIL sh_req got=%b exp=11", {dmem_req, dmem_we}); end
    total++; if (dmem_addr !== 32'h0000_2000) begin bad++; $display("FAIL sh_addr got=%h exp=00002000", dmem_addr); end
    total++; if (dmem_be !== 4'b0011) begin bad++; $display("FAIL sh_be got=%b exp=0011", dmem_be); end
    total++; if (dmem_wdata !== 32'hBEEF_BEEF) begin bad++; $display("FAIL sh_wdata got=%h exp=beefbeef", dmem_wdata); end
    tick;
    total++; if ({dmem_be, dmem_wdata} !== {4'b0011, 32'hBEEF_BEEF}) begin bad++; $display("FAIL sh_stable got=%h exp=%h", {dmem_be, dmem_wdata}, {4'b0011, 32'hBEEF_BEEF}); end
    ack_after(0, 32'h0);
    total++; if ({wb_valid, wb_reg_write} !== 2'b10) begin bad++; $display("FAIL sh_wb got=%b exp=10", {wb_valid, wb_reg_write}); end
    issue(32'h0000_5003, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h1234_56A5, 1'b0, 5'd0);
    total++; if ({dmem_be, dmem_wdata} !== {4'b0001, 32'hA5A5_A5A5}) begin bad++; $display("FAIL sb_lane got=%h exp=%h", {dmem_be, dmem_wdata}, {4'b0001, 32'hA5A5_A5A5}); end
    ack_after(0, 32'h0);
    issue(32'h0000_6000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0077, 1'b0, 5'd0);
    total++; if ({dmem_be, dmem_wdata} !== {4'b1000, 32'h7777_7777}) begin bad++; $display("FAIL sb0_lane got=%h exp=%h", {dmem_be, dmem_wdata}, {4'b1000, 32'h7777_7777}); end
    ack_after(0, 32'h0);
  endtask

  task automatic test_exceptions;
    issue(32'h0000_1003, 1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd7);
    total++; if ({wb_valid, exc_overflow, exc_misaligned, exc_bus} !== 4'b1100) begin bad++; $display("FAIL ovf_flags got=%b exp=1100", {wb_valid, exc_overflow, exc_misaligned, exc_bus}); end
    total++; if ({dmem_req, wb_reg_write} !== 2'b00) begin bad++; $display("FAIL ovf_noacc got=%b exp=00", {dmem_req, wb_reg_write}); end
    issue(32'h0000_1003, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd7);
    total++; if ({wb_valid, exc_overflow, exc_misaligned, exc_bus} !== 4'b1010) begin bad++; $display("FAIL mis_flags got=%b exp=1010", {wb_valid, exc_overflow, exc_misaligned, exc_bus}); end
    total++; if ({dmem_req, wb_reg_write} !== 2'b00) begin bad++; $display("FAIL mis_noacc got=%b exp=00", {dmem_req, wb_reg_write}); end
    tick;
    total++; if ({wb_valid, exc_misaligned, dmem_req} !== 3'b000) begin bad++; $display("FAIL mis_pulse got=%b exp=000", {wb_valid, exc_misaligned, dmem_req}); end
    issue(32'h0000_1001, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 32'h0, 1'b0, 5'd0);
    total++; if ({exc_misaligned, dmem_req} !== 2'b10) begin bad++; $display("FAIL sh_mis got=%b exp=10", {exc_misaligned, dmem_req}); end
  endtask

  task automatic test_timeout;
    int n;
    issue(32'h0000_4000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd4);
    n = 0;
    while (dmem_req && n < 20) begin n++; tick; end
    total++; if (n !== 4) begin bad++; $display("FAIL to_cycles got=%0d exp=4", n); end
    total++; if ({wb_valid, exc_bus, wb_reg_write} !== 3'b110) begin bad++; $display("FAIL to_flags got=%b exp=110", {wb_valid, exc_bus, wb_reg_write}); end
    issue(32'h0000_4004, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd6);
    ack_after(3, 32'hCAFE_F00D);
    total++; if ({wb_valid, exc_bus, wb_reg_write} !== 3'b101) begin bad++; $display("FAIL to_lastack got=%b exp=101", {wb_valid, exc_bus, wb_reg_write}); end
    total++; if (wb_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL to_lastdata got=%h exp=cafef00d", wb_data); end
  endtask

  task automatic test_reset_mid;
    issue(32'h0000_3000, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd2);
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL rm_req got=%b exp=1", dmem_req); end
    rst_n = 1'b0;
    tick;
    total++; if ({dmem_req, wb_valid} !== 2'b00) begin bad++; $display("FAIL rm_drop got=%b exp=00", {dmem_req, wb_valid}); end
    rst_n = 1'b1;
    tick;
    total++; if ({ex_ready, wb_valid} !== 2'b10) begin bad++; $display("FAIL rm_after got=%b exp=10", {ex_ready, wb_valid}); end
  endtask

  task automatic test_back_to_back;
    issue(32'h0000_0011, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b1, 5'd1);
    total++; if ({wb_valid, wb_data} !== {1'b1, 32'h0000_0011}) begin bad++; $display("FAIL b2b_first got=%h exp=%h", {wb_valid, wb_data}, {1'b1, 32'h0000_0011}); end
    issue(32'h0000_0022, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 1'b0, 5'd2);
    total++; if ({wb_valid, wb_data, wb_reg_write, wb_reg_dest} !== {1'b1, 32'h0000_0022, 1'b0, 5'd2}) begin bad++; $display("FAIL b2b_second got=%h exp=%h", {wb_valid, wb_data, wb_reg_write, wb_reg_dest}, {1'b1, 32'h0000_0022, 1'b0, 5'd2}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ex_valid = 1'b0; ex_alu_result = '0; ex_alu_overflow = 1'b0; ex_mem_read = 1'b0;
    ex_mem_write = 1'b0; ex_mem_size = 2'd0; ex_mem_signed = 1'b0; ex_store_data = '0;
    ex_reg_write = 1'b0; ex_reg_dest = '0; dmem_ack = 1'b0; dmem_rdata = '0; rst_n = 1'b0;
    test_reset;
    test_alu;
    test_loads;
    test_stores;
    test_exceptions;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
